fir_seq: RTL and testbench
==========================

# fir_seq

Time-multiplexed FIR sequencer. Owns a circular sample delay line and a double-buffered coefficient bank, and schedules one shared signed multiply-accumulate across all taps, one tap per clock. It produces one rounded, saturated output per accepted input. It sits in front of the FIR output path: upstream pushes samples with a valid/ready handshake, and a host loads coefficients into the shadow bank and requests a bank swap between samples.

## Interface
- D_W, 16, sample width (signed) for fir_in and fir_out
- C_W, 16, coefficient width (signed, Q1.(C_W-1))
- TAPS, 16, number of taps; ≥2
- ACC_W, D_W+C_W+$clog2(TAPS), accumulator width (derived; not overridden)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fir_in valid
- in_ready  out  1  sequencer can accept a sample
- fir_in  in  D_W  signed input sample
- fir_out  out  D_W  signed filtered sample, registered
- out_valid  out  1  one-cycle pulse, fir_out valid
- coef_we  in  1  shadow-bank coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index
- coef_data  in  C_W  signed coefficient
- coef_swap  in  1  request shadow/active bank swap
- coef_pending  out  1  swap requested, not yet applied

## Operation
States: IDLE, MAC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: write fir_in to x[wr_ptr], clear acc, set k=0, go to MAC.
- **MAC**
  - Each cycle: acc += active[k] * x[(wr_ptr-k) mod TAPS].
  - Multiply is signed full precision, sign-extended to ACC_W.
  - k increments. After k=TAPS-1, go to DONE.
- **DONE**
  - Register fir_out = sat(( acc + 2^(C_W-2) ) >>> (C_W-1)).
  - sat clamps to [-2^(D_W-1), 2^(D_W-1)-1].
  - Pulse out_valid, advance wr_ptr (wraps TAPS-1→0), go to IDLE.
- **Coefficients**
  - coef_we writes coef_data into shadow[coef_addr] at any state.
  - coef_addr ≥ TAPS is ignored.
  - coef_swap sets coef_pending.
  - The swap executes on the first edge where state==IDLE and coef_pending=1. At that edge the banks exchange roles and coef_pending clears.
  - If a handshake occurs on the same edge, that sample's MAC uses the new active bank.
  - A coef_we on the swap edge lands in the pre-swap shadow bank, which becomes the active bank.
  - coef_swap while coef_pending=1 has no additional effect.
- **Reset values**
  - State IDLE, wr_ptr=0, k=0, acc=0, delay line all zero.
  - Both banks all zero, coef_pending=0, fir_out=0, out_valid=0.
  - in_ready=1 on the first cycle after reset.
- **Reset mid-operation:** any in-flight sample is discarded and no out_valid is produced.

## Timing
- Handshake at edge t. MAC updates occur at edges t+1..t+TAPS. fir_out/out_valid are registered at edge t+TAPS+1 and stay high for that one cycle only.
- in_ready is 0 from edge t+1 through edge t+TAPS+1. The next acceptance is possible at edge t+TAPS+2.
- Maximum throughput: one sample per TAPS+2 cycles.
- There is no output backpressure. fir_out holds its value until the next DONE.
- in_ready depends only on state (no combinational path from in_valid).

## Structure
- Package fir_pkg:
  - state enum fir_seq_state_t {IDLE, MAC, DONE}
  - ACC_W helper function
  - saturation bounds as functions of D_W
- Sub-module fir_sat_round: combinational round-half-up, arithmetic shift, saturate ACC_W→D_W. Instantiated once, feeding the fir_out register.
- Delay line and banks are register arrays indexed by wr_ptr/k. A single multiplier is mandatory.

## Test plan
All scenarios use TAPS=4, D_W=C_W=16.

1. **Impulse.** Load shadow {0x4000,0x2000,0x0000,0xC000}, pulse coef_swap. Send 0x7FFF, then three 0x0000 samples. Required fir_out sequence: 0x4000, 0x2000, 0x0000, 0xC001.
2. **Latency/throughput.** Hold in_valid=1 continuously. Accepts occur every 6 cycles. out_valid rises exactly 5 edges after each accepting edge. in_ready=0 during MAC/DONE.
3. **Saturation.** All coefficients 0x7FFF. Four samples of 0x7FFF give 0x7FFF on the 4th output. Four samples of 0x8000 give 0x8000 on the 4th output.
4. **Swap timing.**
   - Active bank all 0x4000. Write shadow all 0x2000 and pulse coef_swap mid-MAC.
   - coef_pending stays 1 until the next IDLE edge.
   - The current sample uses 0x4000 and the following sample uses 0x2000.
   - Repeat with coef_swap coincident with a handshake edge: that sample uses the new bank.
5. **Reset mid-MAC.** Assert reset at k=2. No out_valid is produced. After release, in_ready=1, wr_ptr=0, and an impulse reproduces scenario 1's outputs with zero history.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and width/saturation helpers for the FIR sequencer
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} fir_seq_state_t;
  function automatic int acc_width(input int d_w, input int c_w, input int taps);
    return d_w + c_w + $clog2(taps);
  endfunction
  function automatic longint sat_max(input int d_w);
    return (longint'(1) << (d_w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int d_w);
    return -(longint'(1) << (d_w - 1));
  endfunction
endpackage

// File: rtl/fir_sat_round.sv
// fir_sat_round: round-half-up, arithmetic shift by C_W-1, saturate ACC_W to D_W
module fir_sat_round
  import fir_pkg::*;
#(
  parameter int D_W   = 16,
  parameter int C_W   = 16,
  parameter int ACC_W = 36
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [D_W-1:0]   y
);
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(longint'(1) << (C_W - 2));
  localparam logic signed [ACC_W:0] HI  = (ACC_W + 1)'(sat_max(D_W));
  localparam logic signed [ACC_W:0] LO  = (ACC_W + 1)'(sat_min(D_W));
  logic signed [ACC_W:0] sum, sh;
  always_comb begin
    sum = $signed({acc[ACC_W-1], acc}) + RND;
    sh  = sum >>> (C_W - 1);
    y   = sh > HI ? HI[D_W-1:0] : sh < LO ? LO[D_W-1:0] : sh[D_W-1:0];
  end
endmodule

// File: rtl/fir_seq.sv
// fir_seq: time-multiplexed FIR, one shared MAC stepping one tap per clock
module fir_seq
  import fir_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int C_W  = 16,
  parameter int TAPS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [D_W-1:0]    fir_in,
  output logic signed [D_W-1:0]    fir_out,
  output logic                     out_valid,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [C_W-1:0]    coef_data,
  input  logic                     coef_swap,
  output logic                     coef_pending
);
  localparam int ACC_W = acc_width(D_W, C_W, TAPS);
  localparam int A_W   = $clog2(TAPS);
  fir_seq_state_t state, nxt;
  logic [A_W-1:0] wr_ptr, k, idx;
  logic signed [D_W-1:0] x [TAPS];
  logic signed [C_W-1:0] bank [2][TAPS];
  logic sel, swap;
  logic signed [ACC_W-1:0] acc;
  logic signed [D_W+C_W-1:0] prod;
  logic signed [D_W-1:0] rounded;
  always_comb begin
    in_ready = state == IDLE;
    swap     = in_ready && coef_pending;
    idx      = A_W'((int'(wr_ptr) - int'(k) + TAPS) % TAPS);
    prod     = bank[sel][k] * x[idx];
    nxt      = state == IDLE ? (in_valid ? MAC : IDLE)
             : state == MAC  ? (k == A_W'(TAPS - 1) ? DONE : MAC)
             : IDLE;
  end
  fir_sat_round #(.D_W(D_W), .C_W(C_W), .ACC_W(ACC_W)) u_sat (.acc(acc), .y(rounded));
  // bank[sel] is active; writes always land in the other one, so a write on the swap edge goes live
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      k            <= '0;
      acc          <= '0;
      sel          <= 1'b0;
      coef_pending <= 1'b0;
      fir_out      <= '0;
      out_valid    <= 1'b0;
      x            <= '{default: '0};
      bank         <= '{default: '{default: '0}};
    end else begin
      state        <= nxt;
      out_valid    <= state == DONE;
      coef_pending <= swap ? 1'b0 : coef_pending | coef_swap;
      if (swap) sel <= ~sel;
      if (coef_we && int'(coef_addr) < TAPS) bank[~sel][coef_addr] <= coef_data;
      if (in_ready && in_valid) begin
        x[wr_ptr] <= fir_in;
        acc       <= '0;
        k         <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + 1'b1;
      end
      if (state == DONE) begin
        fir_out <= rounded;
        wr_ptr  <= wr_ptr == A_W'(TAPS - 1) ? '0 : wr_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: random and directed stimulus against a sample-level FIR model
module tb_fir_seq;
  localparam int TAPS = 4;
  logic clk = 0, reset = 1, in_valid = 0, coef_we = 0, coef_swap = 0;
  logic in_ready, out_valid, coef_pending;
  logic [15:0] fir_in = 0, coef_data = 0, fir_out;
  logic [1:0] coef_addr = 0;
  int checks = 0, failures = 0, cyc = 0, cnt = 0;
  logic signed [15:0] hist [TAPS], m_act [TAPS], m_shd [TAPS], tmp [TAPS];
  logic [15:0] m_out = 0, y_pend = 0;
  bit pend = 0, m_valid = 0;
  logic [15:0] outs [$];
  int acc_t [$], ov_t [$];

  fir_seq #(.D_W(16), .C_W(16), .TAPS(TAPS)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fir_in(fir_in), .fir_out(fir_out), .out_valid(out_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .coef_pending(coef_pending));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] fir_ref();
    longint s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(m_act[i]) * longint'(hist[i]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // Model: one output per accepted sample, TAPS+1 edges later, computed from the last TAPS samples
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin hist[i] = 0; m_act[i] = 0; m_shd[i] = 0; end
      pend = 0; cnt = 0; m_valid = 0; m_out = 0;
    end else begin
      m_valid = 0;
      if (coef_we) m_shd[coef_addr] = coef_data;
      if (cnt == 0 && pend) begin
        tmp = m_act; m_act = m_shd; m_shd = tmp; pend = 0;
      end else if (coef_swap) pend = 1;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin m_valid = 1; m_out = y_pend; end
      end else if (in_valid) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = fir_in;
        y_pend = fir_ref();
        cnt = TAPS + 1;
        acc_t.push_back(cyc);
      end
    end
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, cnt == 0});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("fir_out", {16'b0, fir_out}, {16'b0, m_out});
    chk("coef_pending", {31'b0, coef_pending}, {31'b0, pend});
    if (out_valid) begin outs.push_back(fir_out); ov_t.push_back(cyc); end
  end

  task automatic send(input logic [15:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send_timeout", 1, 0);
    in_valid = 1; fir_in = v;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic load(input logic [15:0] c0, c1, c2, c3);
    logic [15:0] c [4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      coef_we = 1; coef_addr = 2'(i); coef_data = c[i];
      @(negedge clk);
    end
    coef_we = 0;
  endtask

  task automatic pulse_swap();
    coef_swap = 1; @(negedge clk); coef_swap = 0;
  endtask

  task automatic wait_outs(input int n);
    int t = 0;
    while (outs.size() < n && t < 300) begin @(negedge clk); t++; end
    if (outs.size() < n) chk("wait_outs_timeout", outs.size(), n);
  endtask

  task automatic do_reset();
    reset = 1; repeat (2) @(negedge clk); reset = 0;
  endtask

  initial begin
    int n_ov;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_fir_out", {16'b0, fir_out}, 0);
    chk("rst_coef_pending", {31'b0, coef_pending}, 0);
    // impulse
    outs.delete();
    load(16'h4000, 16'h2000, 16'h0000, 16'hC000);
    pulse_swap();
    send(16'h7FFF); send(0); send(0); send(0);
    wait_outs(4);
    chk("imp0", outs[0], 16'h4000); chk("imp1", outs[1], 16'h2000);
    chk("imp2", outs[2], 16'h0000); chk("imp3", outs[3], 16'hC001);
    // continuous in_valid
    repeat (8) @(negedge clk);
    acc_t.delete(); ov_t.delete();
    in_valid = 1;
    repeat (40) begin fir_in = 16'($urandom); @(negedge clk); end
    in_valid = 0;
    repeat (8) @(negedge clk);
    chk("tp_accepts", {31'b0, acc_t.size() >= 6}, 1);
    for (int i = 0; i + 1 < acc_t.size() && i < ov_t.size(); i++) begin
      chk("tp_latency", ov_t[i] - acc_t[i], 5);
      chk("tp_spacing", acc_t[i+1] - acc_t[i], 6);
    end
    // saturation
    outs.delete();
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    pulse_swap();
    repeat (4) send(16'h7FFF);
    repeat (4) send(16'h8000);
    wait_outs(8);
    chk("sat_pos", outs[3], 16'h7FFF);
    chk("sat_neg", outs[7], 16'h8000);
    // swap timing: mid-MAC request, then one coincident with a handshake
    repeat (8) @(negedge clk);
    do_reset();
    outs.delete();
    load(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    pulse_swap();
    repeat (2) @(negedge clk);
    send(16'h1000);
    pulse_swap();
    load(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    chk("swap_pending_held", {31'b0, coef_pending}, 1);
    send(16'h1000);
    while (!in_ready) @(negedge clk);
    in_valid = 1; fir_in = 16'h1000;
    @(negedge clk);
    pulse_swap();
    load(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    @(negedge clk);
    in_valid = 0;
    wait_outs(4);
    chk("swap_old", outs[0], 16'h0800); chk("swap_new", outs[1], 16'h0800);
    chk("swap_pre", outs[2], 16'h0C00); chk("swap_coinc", outs[3], 16'h2000);
    // reset mid-MAC at k=2
    repeat (8) @(negedge clk);
    send(16'h7FFF);
    repeat (2) @(negedge clk);
    n_ov = ov_t.size();
    reset = 1; @(negedge clk); reset = 0;
    chk("rst_mid_ready", {31'b0, in_ready}, 1);
    repeat (10) @(negedge clk);
    chk("rst_mid_no_out", ov_t.size(), n_ov);
    outs.delete();
    load(16'h4000, 16'h2000, 16'h0000, 16'hC000);
    pulse_swap();
    send(16'h7FFF); send(0); send(0); send(0);
    wait_outs(4);
    chk("rimp0", outs[0], 16'h4000); chk("rimp1", outs[1], 16'h2000);
    chk("rimp2", outs[2], 16'h0000); chk("rimp3", outs[3], 16'hC001);
    // random traffic, coefficient churn and occasional resets
    repeat (2000) begin
      in_valid  = $urandom_range(0, 2) != 0;
      fir_in    = 16'($urandom);
      coef_we   = $urandom_range(0, 3) == 0;
      coef_addr = 2'($urandom);
      coef_data = 16'($urandom);
      coef_swap = $urandom_range(0, 15) == 0;
      reset     = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    {in_valid, coef_we, coef_swap, reset} = '0;
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
